regfile_scoreboard: RTL
=======================

Name: regfile_scoreboard

Overview:
- Parametrised successor to the core's 2-read/1-write integer register file.
- Configurable data width, address width and number of read ports.
- Per-register busy (scoreboard) bits so the issue stage can detect RAW/WAW hazards against in-flight writebacks.
- Sits between decode/issue (reads, reservations, flush) and writeback (write port).

Parameters:
- DATA_WIDTH, 32: bits per register.
- ADDR_WIDTH, 5: register index width; depth = 2**ADDR_WIDTH.
- NUM_READ, 2: number of independent combinational read ports (1..4).

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- readAddress  input  NUM_READ*ADDR_WIDTH  port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- readData  output  NUM_READ*DATA_WIDTH  port i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- readBusy  output  NUM_READ  bit i = addressed register has a pending write.
- writeEnable  input  1  writeback strobe.
- writeAddress  input  ADDR_WIDTH  writeback destination.
- writeData  input  DATA_WIDTH  writeback value.
- reserveEnable  input  1  issue stage requests to mark a destination busy.
- reserveAddress  input  ADDR_WIDTH  destination to reserve.
- reserveAccept  output  1  combinational; reservation taken this cycle.
- flush  input  1  synchronous; clear all busy bits (pipeline squash).
- busyCount  output  ADDR_WIDTH+1  registered popcount of the busy vector.

Behaviour:
- Storage: 2**ADDR_WIDTH x DATA_WIDTH registers plus a 2**ADDR_WIDTH busy vector.
- Reset (asynchronous, any time, including mid-operation):
  - All registers = 0, all busy = 0, busyCount = 0.
  - Outputs settle combinationally: readData = 0, readBusy = 0.
  - reserveAccept follows its equation.
- Register 0:
  - readData always 0; readBusy always 0.
  - Writes are ignored; busy[0] is never set.
  - A reservation to register 0 gives reserveAccept = 1 with no state change.
- Write, on the rising edge when writeEnable=1 and writeAddress!=0:
  - reg[writeAddress] <= writeData.
  - busy[writeAddress] <= 0, unless the same-cycle reservation rule below applies.
  - A write to a non-busy register is legal and updates data only.
- Reservation:
  - reserveAccept = reserveEnable & !flush & (reserveAddress==0 | !busy[reserveAddress] | (writeEnable & writeAddress==reserveAddress)).
  - When accepted and the address is nonzero: busy[reserveAddress] <= 1.
  - Rejection (WAW on a busy register) changes nothing; the issue stage retries.
- Same-address write + reserve in one cycle: the data is written and busy ends the cycle at 1 (new reservation wins).
- Flush:
  - At the edge, all busy <= 0 and any same-cycle reservation is dropped (reserveAccept = 0).
  - A same-cycle write still updates data.
- busyCount:
  - Registered; equals the popcount of the busy vector after each edge.
  - Simultaneous set of one register and clear of another gives a net change of 0.
  - Maximum value 2**ADDR_WIDTH-1 (register 0 is never busy).
- Reads: combinational, zero latency, independent per port; all ports may address the same register.
- Out-of-range values cannot occur; indices are ADDR_WIDTH wide.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: a read port whose address equals a nonzero writeAddress while writeEnable=1 returns writeData and readBusy=0 in the same cycle (write-to-read forwarding).
- The reservation rule is unchanged. If a same-address reservation is also accepted, readBusy still reads 0 that cycle, then 1 after the edge.
- Not defined: reads return stored contents and registered busy; the new value and the cleared busy are visible the cycle after the write edge.

Test Plan:
- Assert reset for 2 cycles, then read all 32 registers on both ports -> readData=0, readBusy=0, busyCount=0. Pulse reset mid-sequence after writes -> immediately 0.
- Write 0xDEADBEEF to x5, then read x5 next cycle -> 0xDEADBEEF. Write 0x1234 to x0, then read x0 -> 0, and busyCount stays 0.
- Reserve x7 -> reserveAccept=1, busyCount=1, readBusy=1 on x7. Reserve x7 again -> reserveAccept=0. Write 0x55 to x7 -> busy clears, busyCount=0.
- Reserve x3, x4, x9 on consecutive cycles, then assert flush while reserving x10 -> reserveAccept=0, busyCount=0 next cycle, and data in x3/x4/x9 is unchanged.
- Busy x8; in the same cycle write x8=0xA5 and reserve x8 -> reserveAccept=1, x8 reads 0xA5, readBusy=1, busyCount unchanged (1).
- With REGFILE_BYPASS_EN: write x12=0xCAFE while port 1 reads x12 -> port 1 shows 0xCAFE that cycle. Without the macro -> port 1 shows the old value that cycle and 0xCAFE the next.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Parametrised multi-read-port register file with per-register busy (scoreboard) bits.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_scoreboard #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] readAddress,
  output logic [NUM_READ*DATA_WIDTH-1:0] readData,
  output logic [NUM_READ-1:0]            readBusy,
  input  logic                           writeEnable,
  input  logic [ADDR_WIDTH-1:0]          writeAddress,
  input  logic [DATA_WIDTH-1:0]          writeData,
  input  logic                           reserveEnable,
  input  logic [ADDR_WIDTH-1:0]          reserveAddress,
  output logic                           reserveAccept,
  input  logic                           flush,
  output logic [ADDR_WIDTH:0]            busyCount
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]      busy_q;
  logic [DEPTH-1:0]      busy_d;
  logic [ADDR_WIDTH:0]   busy_count_q;
  logic [ADDR_WIDTH:0]   busy_count_d;
  logic                  write_en;
  logic                  reserve_set;

  // Register 0 is hardwired: writes to it are dropped here rather than at every consumer.
  assign write_en = writeEnable && (writeAddress != '0);

  assign reserveAccept = reserveEnable && !flush &&
                         ((reserveAddress == '0) ||
                          !busy_q[reserveAddress] ||
                          (writeEnable && (writeAddress == reserveAddress)));

  assign reserve_set = reserveAccept && (reserveAddress != '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (write_en) begin
      mem_q[writeAddress] <= writeData;
    end
  end

  // Reservation is applied after the writeback clear so a same-address pair ends busy.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (write_en) begin
        busy_d[writeAddress] = 1'b0;
      end
      if (reserve_set) begin
        busy_d[reserveAddress] = 1'b1;
      end
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    busy_count_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_count_d = busy_count_d + (ADDR_WIDTH+1)'(busy_d[i]);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q       <= '0;
      busy_count_q <= '0;
    end else begin
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end

  assign busyCount = busy_count_q;

  for (genvar gi = 0; gi < NUM_READ; gi++) begin : gen_read
    logic [ADDR_WIDTH-1:0] port_addr;
    logic [DATA_WIDTH-1:0] port_data;
    logic                  port_busy;
    logic                  port_fwd;

    assign port_addr = readAddress[gi*ADDR_WIDTH +: ADDR_WIDTH];

`ifdef REGFILE_BYPASS_EN
    assign port_fwd = write_en && (writeAddress == port_addr);
`else
    assign port_fwd = 1'b0;
`endif

    // Reset gates the outputs so they read zero while reset is held.
    always_comb begin
      port_data = mem_q[port_addr];
      port_busy = busy_q[port_addr];
      if (reset || (port_addr == '0)) begin
        port_data = '0;
        port_busy = 1'b0;
      end else if (port_fwd) begin
        port_data = writeData;
        port_busy = 1'b0;
      end
    end

    assign readData[gi*DATA_WIDTH +: DATA_WIDTH] = port_data;
    assign readBusy[gi]                          = port_busy;
  end

endmodule
